fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined CPU. It holds the program counter, issues in-order word requests to instruction memory, and buffers returned instructions with their PCs in a small in-flight queue. It presents them to the decode-stage register through a valid/ready handshake. It sits directly upstream of the D pipeline register, whose `data_in` is driven from `d_instr`. Branch/jump redirects from later stages flush the queue and discard in-flight responses.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, in-order imem requests, in-flight queue to decode
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   defined     : a misaligned redirect sets a sticky fetch_err and stops fetching
//                 until the next aligned redirect; the PC keeps the low bits
//   not defined : redirect_pc[1:0] is forced to zero on load and fetch_err is 0
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   imem_req     out  fetch request (credit based, independent of imem_gnt)
//   imem_addr    out  request address, always the PC register
//   imem_gnt     in   request accepted this cycle
//   imem_rvalid  in   in-order response strobe, at least one cycle after grant
//   imem_rdata   in   instruction word of the response
//   redirect     in   one-cycle redirect strobe from later stages
//   redirect_pc  in   new fetch target
//   d_valid      out  head entry holds a returned instruction
//   d_ready      in   decode accepts the head entry
//   d_instr      out  head instruction, 0 when d_valid is 0
//   d_pc         out  head PC, 0 when d_valid is 0
//   fetch_err    out  sticky misaligned-redirect flag

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        fetch_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointers carry one extra wrap bit so that "all DEPTH entries in use"
    // differs from "empty"; the low PW bits index the queue.
    typedef logic [CW-1:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
    localparam ptr_t ONE_P   = ptr_t'(1);

    logic [31:0] pc;
    logic [31:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        fill_ptr;
    ptr_t        rd_ptr;
    ptr_t        discard_cnt;
    logic        run;
    logic        err_hold;

    ptr_t        count;
    ptr_t        unfilled;
    ptr_t        used;
    logic        grant;
    logic        pop;
    logic        rsp_drop;
    logic        rsp_fill;
    logic        rsp_used;
    logic [31:0] redirect_load;

    assign count    = wr_ptr - rd_ptr;
    assign unfilled = wr_ptr - fill_ptr;
    // Queue slots plus responses still owed to a flushed stream; both must
    // fit in DEPTH before another request may be issued.
    assign used     = count + discard_cnt;

    // run holds the request low until the first edge after reset release.
    assign imem_req  = run && !redirect && !err_hold && (used < DEPTH_P);
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    // Entries between rd_ptr and fill_ptr are allocated and filled.
    assign d_valid = (fill_ptr != rd_ptr);
    assign d_instr = d_valid ? instr_mem[rd_ptr[PW-1:0]] : 32'h0;
    assign d_pc    = d_valid ? pc_mem[rd_ptr[PW-1:0]]    : 32'h0;
    assign pop     = d_valid && d_ready;

    // Stale responses are consumed first; a response with nothing
    // outstanding matches neither case and is ignored.
    assign rsp_drop = imem_rvalid && (discard_cnt != '0);
    assign rsp_fill = imem_rvalid && (discard_cnt == '0) && (unfilled != '0);
    assign rsp_used = rsp_drop || rsp_fill;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_load = redirect_pc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_hold <= 1'b0;
        end else if (redirect) begin
            err_hold <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_err = err_hold;
`else
    logic unused_low_bits;

    assign redirect_load   = {redirect_pc[31:2], 2'b00};
    assign err_hold        = 1'b0;
    assign fetch_err       = 1'b0;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            wr_ptr      <= '0;
            fill_ptr    <= '0;
            rd_ptr      <= '0;
            discard_cnt <= '0;
            run         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= 32'h0;
                instr_mem[i] <= 32'h0;
            end
        end else begin
            run <= 1'b1;
            if (redirect) begin
                // Every unfilled entry still has a response coming back;
                // those become discards, less the one consumed right now.
                pc          <= redirect_load;
                wr_ptr      <= '0;
                fill_ptr    <= '0;
                rd_ptr      <= '0;
                discard_cnt <= unfilled + discard_cnt - (rsp_used ? ONE_P : '0);
            end else begin
                if (grant) begin
                    pc_mem[wr_ptr[PW-1:0]] <= pc;
                    wr_ptr                 <= wr_ptr + ONE_P;
                    pc                     <= pc + 32'd4;
                end
                if (rsp_drop) begin
                    discard_cnt <= discard_cnt - ONE_P;
                end
                if (rsp_fill) begin
                    instr_mem[fill_ptr[PW-1:0]] <= imem_rdata;
                    fill_ptr                    <= fill_ptr + ONE_P;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ONE_P;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory and decode
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_3000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic        fetch_err;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_instr     (d_instr),
        .d_pc        (d_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } mreq_t;

    mreq_t       mem_q[$];   // granted requests the memory still owes a response for
    logic [31:0] exp_q[$];   // PCs of the current stream, in order, not yet taken by decode
    logic [31:0] acc_log[$]; // every PC decode accepted
    int          epoch = 0;
    logic [31:0] m_pc = RPC;
    bit          m_err = 0;
    bit          m_run = 0;
    int          n_grant = 0;
    int          checks = 0;
    int          errors = 0;

    int          p_gnt = 0, p_rv = 0, p_rdy = 0, p_redir = 0, p_spur = 0;
    bit          redir_req = 0;
    logic [31:0] redir_pc = 32'h0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
        if (acc_log.size() > idx) begin
            chk(name, acc_log[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s actual=none accepted expected=%h", name, exp);
        end
    endtask

    // Monitor / scoreboard: compares the DUT against the reference rules once
    // per cycle, then advances the reference state by what happened this cycle.
    always @(negedge clk) begin : mon
        int          stale;
        int          cur_out;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] e;
        mreq_t       r;
        if (reset === 1'b1) begin
            stale   = 0;
            cur_out = 0;
            foreach (mem_q[i]) begin
                if (mem_q[i].epoch == epoch) cur_out++;
                else stale++;
            end
            exp_valid = (exp_q.size() > cur_out);
            exp_req   = m_run && !redirect && !m_err && (exp_q.size() + stale < DEPTH);
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            chk("imem_addr", imem_addr, m_pc);
            chk("d_valid", {31'b0, d_valid}, {31'b0, exp_valid});
            chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
            if (!d_valid) begin
                chk("d_instr_idle", d_instr, 32'h0);
                chk("d_pc_idle", d_pc, 32'h0);
            end
            if (d_valid && d_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected actual pc=%h expected=no instruction", d_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("d_pc", d_pc, e);
                    chk("d_instr", d_instr, instr_of(e));
                end
                acc_log.push_back(d_pc);
            end
            if (imem_rvalid && mem_q.size() > 0) mem_q.delete(0);
            if (redirect) begin
                exp_q.delete();
                epoch++;
`ifdef FETCH_ALIGN_CHECK_EN
                m_pc  = redirect_pc;
                m_err = (redirect_pc[1:0] != 2'b00);
`else
                m_pc  = {redirect_pc[31:2], 2'b00};
`endif
            end else if (exp_req && imem_gnt) begin
                r.addr  = m_pc;
                r.epoch = epoch;
                mem_q.push_back(r);
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                n_grant++;
            end
            m_run = 1;
        end
    end

    // One cycle of stimulus: drive at posedge+1, return at posedge+3.
    task automatic step();
        logic [31:0] r;
        @(posedge clk);
        #1;
        imem_gnt = ($urandom_range(99) < p_gnt);
        if (mem_q.size() > 0 && $urandom_range(99) < p_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mem_q[0].addr);
        end else if (mem_q.size() == 0 && $urandom_range(99) < p_spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        d_ready = ($urandom_range(99) < p_rdy);
        r = $urandom;
        if (redir_req) begin
            redirect    = 1'b1;
            redirect_pc = redir_pc;
            redir_req   = 0;
        end else if ($urandom_range(99) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = (r[31:29] == 3'b000) ? {28'hFFF_FFFF, r[3:0]} : {16'h0000, r[15:0]};
`ifdef FETCH_ALIGN_CHECK_EN
            redirect_pc[1:0] = 2'b00;
`endif
        end else begin
            redirect    = 1'b0;
            redirect_pc = r;
        end
        #2;
    endtask

    task automatic set_p(input int g, input int v, input int d, input int rd, input int sp);
        p_gnt = g; p_rv = v; p_rdy = d; p_redir = rd; p_spur = sp;
    endtask

    task automatic drain();
        set_p(0, 100, 100, 0, 0);
        repeat (8) step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, "_valid"}, {31'b0, d_valid}, 32'h0);
        chk({tag, "_instr"}, d_instr, 32'h0);
        chk({tag, "_pc"}, d_pc, 32'h0);
        chk({tag, "_err"}, {31'b0, fetch_err}, 32'h0);
        chk({tag, "_addr"}, imem_addr, RPC);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          a0;
        logic [31:0] base;
        reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect = 1'b0; redirect_pc = 32'h0; d_ready = 1'b0;

        // Reset, then first fetches with an ideal memory and decode.
        step();
        step();
        chk_reset_state("rst");
        set_p(100, 100, 100, 0, 0);
        reset = 1'b1;
        step();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, RPC);
        step();
        chk("lat_n1_valid", {31'b0, d_valid}, 32'h0);
        step();
        chk("lat_n2_valid", {31'b0, d_valid}, 32'h1);
        chk("lat_n2_pc", d_pc, RPC);
        step();
        chk("lat_n3_pc", d_pc, RPC + 32'd4);
        repeat (4) step();
        #3;
        chk_acc("seq0", 0, RPC);
        chk_acc("seq1", 1, RPC + 32'd4);
        chk_acc("seq2", 2, RPC + 32'd8);

        // Decode stalls for 5 cycles: only DEPTH grants fit.
        drain();
        #3;
        n0 = n_grant;
        base = m_pc;
        set_p(100, 100, 0, 0, 0);
        repeat (5) step();
        chk("stall_req_low", {31'b0, imem_req}, 32'h0);
        #3;
        chk("stall_grants", n_grant - n0, 32'd2);
        a0 = acc_log.size();
        set_p(100, 100, 100, 0, 0);
        repeat (8) step();
        #3;
        chk_acc("stall_rel0", a0, base);
        chk_acc("stall_rel1", a0 + 1, base + 32'd4);
        chk_acc("stall_rel2", a0 + 2, base + 32'd8);

        // Redirect with two responses outstanding.
        drain();
        set_p(100, 0, 100, 0, 0);
        repeat (2) step();
        redir_req = 1; redir_pc = 32'h0000_3100;
        step();
        chk("redir_req_low", {31'b0, imem_req}, 32'h0);
        set_p(100, 100, 100, 0, 0);
        step();
        chk("redir_addr", imem_addr, 32'h0000_3100);
        chk("redir_valid", {31'b0, d_valid}, 32'h0);
        a0 = acc_log.size();
        repeat (8) step();
        #3;
        chk_acc("redir_first", a0, 32'h0000_3100);

        // Redirect coinciding with a response and a pop.
        drain();
        set_p(100, 100, 100, 0, 0);
        repeat (2) step();
        redir_req = 1; redir_pc = 32'h0000_3300;
        step();
        chk("same_pop", {31'b0, d_valid && d_ready}, 32'h1);
        chk("same_rsp", {31'b0, imem_rvalid}, 32'h1);
        step();
        chk("same_addr", imem_addr, 32'h0000_3300);
        chk("same_valid", {31'b0, d_valid}, 32'h0);
        chk("same_req", {31'b0, imem_req}, 32'h1);
        a0 = acc_log.size();
        repeat (6) step();
        #3;
        chk_acc("same_first", a0, 32'h0000_3300);

        // PC wrap at the top of the address space.
        drain();
        set_p(0, 100, 100, 0, 0);
        redir_req = 1; redir_pc = 32'hFFFF_FFFC;
        step();
        set_p(100, 100, 100, 0, 0);
        step();
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
        chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr_zero", imem_addr, 32'h0000_0000);

`ifdef FETCH_ALIGN_CHECK_EN
        drain();
        set_p(100, 100, 100, 0, 0);
        redir_req = 1; redir_pc = 32'h0000_3102;
        step();
        step();
        chk("align_err", {31'b0, fetch_err}, 32'h1);
        chk("align_req", {31'b0, imem_req}, 32'h0);
        chk("align_addr", imem_addr, 32'h0000_3102);
        repeat (3) step();
        chk("align_hold", {31'b0, imem_req}, 32'h0);
        redir_req = 1; redir_pc = 32'h0000_3200;
        step();
        step();
        chk("align_clr_err", {31'b0, fetch_err}, 32'h0);
        chk("align_clr_req", {31'b0, imem_req}, 32'h1);
        a0 = acc_log.size();
        repeat (6) step();
        #3;
        chk_acc("align_resume", a0, 32'h0000_3200);
`endif

        // Random traffic with a reset in the middle.
        set_p(70, 60, 70, 4, 10);
        repeat (700) step();
        set_p(70, 60, 70, 0, 0);
        reset = 1'b0;
        mem_q.delete();
        exp_q.delete();
        m_pc  = RPC;
        m_err = 0;
        m_run = 0;
        epoch++;
        step();
        chk_reset_state("midrst");
        step();
        reset = 1'b1;
        set_p(70, 60, 70, 4, 10);
        repeat (800) step();
        drain();
        #3;
        chk("final_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
